datamemory_param: RTL and testbench

Parametrised single-port synchronous data memory, the next generation of the processor's data memory. Adds configurable width and depth, per-byte write enables, a read-valid strobe, out-of-range detection and a hardware clear sequence after reset. Sits on the datapath load/store port; the control unit must wait for busy=0 before issuing accesses.

---
 rtl/datamemory_param_pkg.sv | 29 ++
 rtl/datamemory_param_if.sv | 35 +++
 rtl/datamemory_bytelane.sv | 36 +++
 rtl/datamemory_param.sv | 134 +++++++++++++
 tb/tb_datamemory_param.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/datamemory_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datamemory_param_pkg
// Description : Shared definitions for the parametrised data memory: FSM state
//               encoding and helpers that size the byte lanes and the storage
//               index from the top-level parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package datamemory_param_pkg;

  // Two-state controller: CLEAR zeroes the array after reset, IDLE serves
  // the load/store port.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Number of byte lanes in a word (NBYTES = DATA_W/8).
  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

  // Bits needed to index DEPTH entries; a one-entry array still gets one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/datamemory_param_if.sv
`default_nettype none
// ============================================================================
// Module      : datamemory_param_if
// Description : Load/store port bundle of the data memory.
//               master : datapath side (drives ce/we/be/address/dataIn)
//               slave  : memory side  (drives dataOut/rd_valid/busy/addr_err)
// Revision    : 1.0 - initial release
// ============================================================================
interface datamemory_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  localparam int NBYTES = DATA_W / 8;

  logic              ce;
  logic              we;
  logic [NBYTES-1:0] be;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              rd_valid;
  logic              busy;
  logic              addr_err;

  modport master (
    output ce, we, be, address, dataIn,
    input  dataOut, rd_valid, busy, addr_err
  );

  modport slave (
    input  ce, we, be, address, dataIn,
    output dataOut, rd_valid, busy, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/datamemory_bytelane.sv
`default_nettype none
// ============================================================================
// Module      : datamemory_bytelane
// Description : One 8-bit wide, DEPTH-deep storage lane with its own write
//               enable. Write is synchronous; read is asynchronous, the
//               owner registers the result.
// Ports       : clk   - rising-edge clock
//               we    - lane write enable
//               idx   - entry index (caller guarantees idx < DEPTH on write)
//               wdata - byte to store
//               rdata - byte currently stored at idx
// Revision    : 1.0 - initial release
// ============================================================================
module datamemory_bytelane #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [IDX_W-1:0] idx,
  input  wire logic [7:0]       wdata,
  output logic      [7:0]       rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule
`default_nettype wire

// File: rtl/datamemory_param.sv
`default_nettype none
// ============================================================================
// Module      : datamemory_param
// Description : Parametrised single-port synchronous data memory with byte
//               write enables, read-valid strobe, out-of-range detection and
//               a hardware clear sequence that runs after every reset.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - load/store port (slave modport):
//                      ce/we/be/address/dataIn in,
//                      dataOut (registered), rd_valid, busy, addr_err out
// Revision    : 1.0 - initial release
// ============================================================================
module datamemory_param
  import datamemory_param_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input wire logic          clk,
  input wire logic          rst,
  datamemory_param_if.slave bus
);

  localparam int NBYTES = byte_lanes(DATA_W);
  localparam int IDX_W  = idx_width(DEPTH);
  // One extra bit so DEPTH = 2**ADDR_W is representable as a terminal count.
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                rd_valid_q, rd_valid_d;
  logic                addr_err_q, addr_err_d;
  logic                busy_q, busy_d;

  logic                in_range;
  logic [NBYTES-1:0]   mem_we;
  logic [IDX_W-1:0]    lane_idx;
  logic [DATA_W-1:0]   lane_wdata;
  logic [DATA_W-1:0]   lane_rdata;

  assign in_range = ({1'b0, bus.address} < DEPTH_C);

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    busy_d     = busy_q;
    mem_we     = '0;
    lane_idx   = bus.address[IDX_W-1:0];
    lane_wdata = bus.dataIn;

    case (state_q)
      ST_CLEAR: begin
        // Port inputs are ignored; every lane writes zero at the counter.
        mem_we     = '1;
        lane_idx   = clr_cnt_q[IDX_W-1:0];
        lane_wdata = '0;
        dout_d     = '0;
        clr_cnt_d  = clr_cnt_q + CNT_W'(1);
        if (clr_cnt_q == LAST_C) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        if (!bus.ce) begin
          dout_d = '0;
        end else if (!in_range) begin
          // Out-of-range writes are dropped; reads complete with zero data.
          addr_err_d = 1'b1;
          if (!bus.we) begin
            dout_d     = '0;
            rd_valid_d = 1'b1;
          end
        end else if (bus.we) begin
          mem_we = bus.be;
        end else begin
          dout_d     = lane_rdata;
          rd_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
      busy_q     <= busy_d;
    end
  end

  for (genvar k = 0; k < NBYTES; k++) begin : g_lane
    datamemory_bytelane #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_lane (
      .clk   (clk),
      // A store coinciding with reset must not land in the array.
      .we    (mem_we[k] & ~rst),
      .idx   (lane_idx),
      .wdata (lane_wdata[8*k +: 8]),
      .rdata (lane_rdata[8*k +: 8])
    );
  end

  assign bus.dataOut  = dout_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.addr_err = addr_err_q;
  assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_datamemory_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_datamemory_param
// Description : Self-checking bench for datamemory_param (DATA_W=32, ADDR_W=4,
//               DEPTH=12). Expected port responses are pushed to a queue
//               when an access is driven and popped when the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datamemory_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
  localparam int NB     = DATA_W / 8;

  typedef struct {
    logic [DATA_W-1:0] dout;
    logic              rv;
    logic              ae;
    string             tag;
  } exp_t;

  logic clk;
  logic rst;

  datamemory_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  datamemory_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_fail   = 0;
  exp_t              sb_q[$];
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_dout;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one access at the falling edge, predict the response, and compare
  // after the rising edge that samples it.
  task automatic access(input string tag, input logic ce, input logic we,
                        input logic [NB-1:0] be, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data);
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.ce = ce; bus.we = we; bus.be = be; bus.address = addr; bus.dataIn = data;
    e.tag = tag;
    e.ae  = 1'b0;
    e.rv  = 1'b0;
    e.dout = exp_dout;
    if (!ce) begin
      e.dout = '0;
    end else if (int'(addr) >= DEPTH) begin
      e.ae = 1'b1;
      if (!we) begin e.dout = '0; e.rv = 1'b1; end
    end else if (we) begin
      for (int k = 0; k < NB; k++)
        if (be[k]) model[addr][8*k +: 8] = data[8*k +: 8];
    end else begin
      e.dout = model[addr];
      e.rv   = 1'b1;
    end
    exp_dout = e.dout;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({got.tag, "_dout"},  bus.dataOut, got.dout);
    check({got.tag, "_rv"},    DATA_W'(bus.rd_valid), DATA_W'(got.rv));
    check({got.tag, "_aerr"},  DATA_W'(bus.addr_err), DATA_W'(got.ae));
  endtask

  // Called at the falling edge where rst has just been released. Counts the
  // cycles busy stays high and checks outputs stay quiet meanwhile.
  task automatic wait_clear(input string tag);
    int n = 0;
    while (bus.busy === 1'b1 && n < 4 * DEPTH) begin
      check({tag, "_clr_dout"}, bus.dataOut, '0);
      check({tag, "_clr_rv"},   DATA_W'(bus.rd_valid), '0);
      n++;
      @(posedge clk);
      #1;
    end
    bus.ce = 1'b0;
    check({tag, "_busy_cycles"}, DATA_W'(n), DATA_W'(DEPTH));
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_dout = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, bus.dataOut, '0);
    check({tag, "_rv"},   DATA_W'(bus.rd_valid), '0);
    check({tag, "_aerr"}, DATA_W'(bus.addr_err), '0);
    check({tag, "_busy"}, DATA_W'(bus.busy), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.ce = 1'b0; bus.we = 1'b0; bus.be = '0; bus.address = '0; bus.dataIn = '0;
    exp_dout = '0;

    // Power-on reset for two cycles; a store to address 0 is held throughout
    // the clear and must have no effect.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    bus.ce = 1'b1; bus.we = 1'b1; bus.be = '1; bus.address = '0;
    bus.dataIn = 32'hFFFF_FFFF;
    wait_clear("clr0");

    for (int i = 0; i < DEPTH; i++) access("clr_rd", 1, 0, '0, ADDR_W'(i), '0);

    // Full-word writes then back-to-back reads.
    access("wr0", 1, 1, 4'hF, 4'd0, 32'd1000);
    access("wr1", 1, 1, 4'hF, 4'd1, 32'd5000);
    access("wr2", 1, 1, 4'hF, 4'd2, 32'd2000);
    access("wr3", 1, 1, 4'hF, 4'd3, 32'd3000);
    for (int i = 0; i < 4; i++) access("rd_b2b", 1, 0, '0, ADDR_W'(i), '0);

    // Byte enables, be=0 and read-after-write.
    access("wr5",     1, 1, 4'hF,    4'd5, 32'h1122_3344);
    access("wr5_be",  1, 1, 4'b0101, 4'd5, 32'hAABB_CCDD);
    access("rd5_be",  1, 0, '0,      4'd5, '0);
    access("wr5_be0", 1, 1, 4'b0000, 4'd5, 32'h5555_5555);
    access("rd5_be0", 1, 0, '0,      4'd5, '0);
    access("wr11",    1, 1, 4'b1010, 4'd11, 32'hCAFE_BABE);
    access("rd11",    1, 0, '0,      4'd11, '0);

    // Out of range: dropped writes, zero-data reads, ce low afterwards.
    access("oor_wr13", 1, 1, 4'hF, 4'd13, 32'h0000_DEAD);
    access("oor_wr12", 1, 1, 4'hF, 4'd12, 32'h1234_5678);
    access("oor_rd13", 1, 0, '0,   4'd13, '0);
    access("rd1",      1, 0, '0,   4'd1,  '0);
    access("ce_low",   0, 0, '0,   4'd1,  '0);
    access("oor_rd15", 1, 0, '0,   4'd15, '0);
    for (int i = 0; i < DEPTH; i++) access("post_oor", 1, 0, '0, ADDR_W'(i), '0);

    // Reset during a read stream.
    access("rs_rd2", 1, 0, '0, 4'd2, '0);
    @(negedge clk);
    rst = 1'b1; bus.ce = 1'b1; bus.we = 1'b0; bus.address = 4'd2;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_stream");
    @(negedge clk);
    rst = 1'b0;
    wait_clear("clr1");
    access("rd2_cleared", 1, 0, '0, 4'd2, '0);

    // Reset while the clear counter sits at 7.
    access("wr4", 1, 1, 4'hF, 4'd4, 32'h0BAD_F00D);
    @(negedge clk);
    rst = 1'b1; bus.ce = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_clr7");
    @(negedge clk);
    rst = 1'b0;
    wait_clear("clr2");
    access("rd4_cleared", 1, 0, '0, 4'd4, '0);
    access("rd0_cleared", 1, 0, '0, 4'd0, '0);

    check("sb_empty", DATA_W'(sb_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
